// File: rtl/rca_wb_serializer.sv
// Buffers RCA writeback bundles in a small FIFO and drains each bundle as a
// sequence of single-register writebacks over a valid/ack handshake.
module rca_wb_serializer #(
    parameter int XLEN            = 32,
    parameter int NUM_WRITE_PORTS = 2,
    parameter int ID_W            = 3,
    parameter int ADDR_W          = 5,
    parameter int DEPTH           = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    rca_done,
    input  logic [ID_W-1:0]                         rca_id,
    input  logic [NUM_WRITE_PORTS-1:0][XLEN-1:0]    rca_rd,
    input  logic [NUM_WRITE_PORTS-1:0][ADDR_W-1:0]  rca_dest_addr,
    input  logic [NUM_WRITE_PORTS-1:0]              rca_dest_we,
    output logic                                    rca_issue_ok,
    output logic                                    wb_valid,
    output logic [ID_W-1:0]                         wb_id,
    output logic [ADDR_W-1:0]                       wb_addr,
    output logic [XLEN-1:0]                         wb_data,
    output logic                                    wb_we,
    output logic                                    wb_last,
    input  logic                                    wb_ack,
    output logic                                    overflow_err
);

    localparam int NWP   = NUM_WRITE_PORTS;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    logic [ID_W-1:0]                id_mem_q   [DEPTH];
    logic [NWP-1:0][XLEN-1:0]       rd_mem_q   [DEPTH];
    logic [NWP-1:0][ADDR_W-1:0]     addr_mem_q [DEPTH];
    logic [NWP-1:0]                 we_mem_q   [DEPTH];

    state_t             state_q, state_d;
    logic [NWP-1:0]     mask_q, mask_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;

    logic [PTR_W-1:0]   rd_ptr_nx_s;
    logic [NWP-1:0]     low_s;
    logic [NWP-1:0]     rest_s;
    logic               last_s;
    logic               valid_s;
    logic               full_s;
    logic               push_s;
    logic               pop_s;
    logic [ADDR_W-1:0]  beat_addr_s;
    logic [XLEN-1:0]    beat_data_s;

    // Current beat selection: lowest remaining write-enable bit of the head entry.
    always_comb begin
        valid_s     = (state_q == ST_DRAIN);
        rd_ptr_nx_s = rd_ptr_q + PTR_W'(1);
        low_s       = mask_q & (~mask_q + NWP'(1));
        rest_s      = mask_q & ~low_s;
        last_s      = (rest_s == {NWP{1'b0}});
        beat_addr_s = {ADDR_W{1'b0}};
        beat_data_s = {XLEN{1'b0}};
        for (int i = 0; i < NWP; i++) begin
            beat_addr_s = beat_addr_s | (low_s[i] ? addr_mem_q[rd_ptr_q][i] : {ADDR_W{1'b0}});
            beat_data_s = beat_data_s | (low_s[i] ? rd_mem_q[rd_ptr_q][i]   : {XLEN{1'b0}});
        end
    end

    // Push/pop decisions, pointer/count bookkeeping and sticky overflow.
    always_comb begin
        full_s     = (count_q == CNT_W'(DEPTH));
        pop_s      = valid_s && wb_ack && last_s;
        push_s     = rca_done && (!full_s || pop_s);
        wr_ptr_d   = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d   = pop_s ? rd_ptr_nx_s : rd_ptr_q;
        count_d    = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
        overflow_d = overflow_q || (rca_done && !push_s);
        // The RCA needs one cycle from issue to done, so reserve the last slot.
        rca_issue_ok = (count_q < CNT_W'(DEPTH - 1)) ||
                       ((count_q == CNT_W'(DEPTH - 1)) && !rca_done);
    end

    // Drain FSM: reloads the working mask whenever a new head becomes current.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        case (state_q)
            ST_IDLE: begin
                if (push_s) begin
                    state_d = ST_DRAIN;
                    mask_d  = rca_dest_we;
                end else begin
                    mask_d  = {NWP{1'b0}};
                end
            end
            ST_DRAIN: begin
                if (wb_ack) begin
                    if (!last_s) begin
                        mask_d = rest_s;
                    end else if (count_q > CNT_W'(1)) begin
                        mask_d = we_mem_q[rd_ptr_nx_s];
                    end else if (push_s) begin
                        mask_d = rca_dest_we;
                    end else begin
                        state_d = ST_IDLE;
                        mask_d  = {NWP{1'b0}};
                    end
                end else begin
                    mask_d = mask_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                mask_d  = {NWP{1'b0}};
            end
        endcase
    end

    // Writeback port, driven only from registered state.
    always_comb begin
        wb_valid     = valid_s;
        wb_id        = valid_s ? id_mem_q[rd_ptr_q] : {ID_W{1'b0}};
        wb_addr      = valid_s ? beat_addr_s : {ADDR_W{1'b0}};
        wb_data      = valid_s ? beat_data_s : {XLEN{1'b0}};
        wb_we        = valid_s && (mask_q != {NWP{1'b0}});
        wb_last      = valid_s && last_s;
        overflow_err = overflow_q;
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mask_q     <= {NWP{1'b0}};
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Bundle storage; contents are only meaningful for occupied entries.
    always_ff @(posedge clk) begin
        if (push_s) begin
            id_mem_q[wr_ptr_q]   <= rca_id;
            rd_mem_q[wr_ptr_q]   <= rca_rd;
            addr_mem_q[wr_ptr_q] <= rca_dest_addr;
            we_mem_q[wr_ptr_q]   <= rca_dest_we;
        end
    end

endmodule

// File: tb/tb_rca_wb_serializer.sv
// Scoreboard bench for rca_wb_serializer: a bundle-level model predicts the
// beat stream and occupancy; a negedge monitor compares every presented beat.
module tb_rca_wb_serializer;

    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             rca_done;
    logic [2:0]       rca_id;
    logic [1:0][31:0] rca_rd;
    logic [1:0][4:0]  rca_dest_addr;
    logic [1:0]       rca_dest_we;
    logic             rca_issue_ok;
    logic             wb_valid;
    logic [2:0]       wb_id;
    logic [4:0]       wb_addr;
    logic [31:0]      wb_data;
    logic             wb_we;
    logic             wb_last;
    logic             wb_ack;
    logic             overflow_err;

    rca_wb_serializer #(
        .XLEN(32), .NUM_WRITE_PORTS(2), .ID_W(3), .ADDR_W(5), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .rca_done(rca_done), .rca_id(rca_id),
        .rca_rd(rca_rd), .rca_dest_addr(rca_dest_addr), .rca_dest_we(rca_dest_we),
        .rca_issue_ok(rca_issue_ok), .wb_valid(wb_valid), .wb_id(wb_id),
        .wb_addr(wb_addr), .wb_data(wb_data), .wb_we(wb_we), .wb_last(wb_last),
        .wb_ack(wb_ack), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  id;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        we;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    mcount  = 0;
    logic  exp_ovf = 1'b0;
    int    total   = 0;
    int    bad     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, req, $time);
        end
    endtask

    // Model: one queue of expected beats plus a count of bundles held.
    always @(negedge clk) begin
        beat_t b;
        logic  retire;
        logic  exp_ok;
        int    n;
        if (rst) begin
            exp_q.delete();
            mcount  = 0;
            exp_ovf = 1'b0;
        end else begin
            retire = 1'b0;
            exp_ok = (mcount < DEPTH - 1) || (mcount == DEPTH - 1 && !rca_done);
            check("issue_ok", 32'(rca_issue_ok), 32'(exp_ok));
            check("overflow_err", 32'(overflow_err), 32'(exp_ovf));
            check("wb_valid", 32'(wb_valid), 32'(exp_q.size() != 0));
            if (wb_valid && exp_q.size() != 0) begin
                b = exp_q[0];
                check("wb_id", 32'(wb_id), 32'(b.id));
                check("wb_addr", 32'(wb_addr), 32'(b.addr));
                check("wb_data", wb_data, b.data);
                check("wb_we", 32'(wb_we), 32'(b.we));
                check("wb_last", 32'(wb_last), 32'(b.last));
                if (wb_ack) begin
                    void'(exp_q.pop_front());
                    if (b.last) begin
                        mcount--;
                        retire = 1'b1;
                    end
                end
            end
            if (rca_done) begin
                if (mcount < DEPTH || retire) begin
                    n = 0;
                    for (int p = 0; p < 2; p++) begin
                        if (rca_dest_we[p]) begin
                            b.id = rca_id; b.addr = rca_dest_addr[p];
                            b.data = rca_rd[p]; b.we = 1'b1; b.last = 1'b0;
                            exp_q.push_back(b);
                            n++;
                        end
                    end
                    if (n == 0) begin
                        b.id = rca_id; b.addr = 5'd0; b.data = 32'd0; b.we = 1'b0; b.last = 1'b1;
                        exp_q.push_back(b);
                    end else begin
                        exp_q[exp_q.size() - 1].last = 1'b1;
                    end
                    mcount++;
                end else begin
                    exp_ovf = 1'b1;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; rca_done = 1'b0; wb_ack = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        @(negedge clk);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_id", 32'(wb_id), 32'd0);
        check("rst_wb_addr", 32'(wb_addr), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_wb_we", 32'(wb_we), 32'd0);
        check("rst_wb_last", 32'(wb_last), 32'd0);
        check("rst_overflow", 32'(overflow_err), 32'd0);
        check("rst_issue_ok", 32'(rca_issue_ok), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] id, input logic [1:0] we,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [4:0] a0, input logic [4:0] a1);
        rca_id = id; rca_dest_we = we;
        rca_rd[0] = d0; rca_rd[1] = d1;
        rca_dest_addr[0] = a0; rca_dest_addr[1] = a1;
        rca_done = 1'b1;
        cyc();
        rca_done = 1'b0;
    endtask

    task automatic drain();
        wb_ack = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) cyc();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout actual=%0d beats left required=0", exp_q.size());
        end
    endtask

    initial begin
        rst = 1'b1; rca_done = 1'b0; wb_ack = 1'b0;
        rca_id = 3'd0; rca_rd = '0; rca_dest_addr = '0; rca_dest_we = 2'b00;
        do_reset();

        // Two-beat bundle under continuous ack.
        wb_ack = 1'b1;
        push(3'd2, 2'b11, 32'hA, 32'hB, 5'd5, 5'd6);
        drain();

        // Single high port, then an empty mask.
        push(3'd3, 2'b10, 32'h11, 32'h22, 5'd7, 5'd8);
        push(3'd4, 2'b00, 32'h33, 32'h44, 5'd9, 5'd10);
        drain();

        // Back-pressure: beat must hold for 5 cycles.
        wb_ack = 1'b0;
        push(3'd5, 2'b11, 32'hCAFE, 32'hBEEF, 5'd1, 5'd2);
        repeat (5) cyc();
        wb_ack = 1'b1;
        cyc();
        wb_ack = 1'b0;
        repeat (2) cyc();
        drain();

        // Fill to DEPTH, then overflow drops one bundle.
        wb_ack = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            push(3'(i), 2'b11, 32'(i * 16 + 1), 32'(i * 16 + 2), 5'(i + 10), 5'(i + 20));
        push(3'd7, 2'b01, 32'hDEAD, 32'h0, 5'd31, 5'd0);
        cyc();
        drain();

        // Full FIFO with head retiring in the same cycle as a push.
        do_reset();
        wb_ack = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            push(3'(i + 1), 2'b00, 32'h0, 32'h0, 5'd0, 5'd0);
        wb_ack = 1'b1;
        push(3'd6, 2'b01, 32'h5A5A, 32'h0, 5'd12, 5'd0);
        wb_ack = 1'b0;
        repeat (2) cyc();
        drain();

        // Reset in the middle of draining three bundles.
        wb_ack = 1'b0;
        for (int i = 0; i < 3; i++)
            push(3'(i + 2), 2'b11, 32'(i + 100), 32'(i + 200), 5'(i + 3), 5'(i + 13));
        wb_ack = 1'b1;
        cyc();
        wb_ack = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        wb_ack = 1'b1;
        push(3'd1, 2'b11, 32'h77, 32'h88, 5'd4, 5'd14);
        drain();

        // Randomized traffic with random back-pressure.
        for (int i = 0; i < 600; i++) begin
            logic ok;
            rca_done = 1'b0;
            ok = rca_issue_ok;
            wb_ack = ($urandom_range(9) < 7);
            rca_id = 3'($urandom);
            rca_rd[0] = $urandom; rca_rd[1] = $urandom;
            rca_dest_addr[0] = 5'($urandom); rca_dest_addr[1] = 5'($urandom);
            rca_dest_we = 2'($urandom);
            rca_done = ($urandom_range(2) == 0) && (ok || $urandom_range(15) == 0);
            rst = ($urandom_range(299) == 0);
            cyc();
        end
        rca_done = 1'b0;
        rst = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
